// File: rtl/message_frame_arbiter.sv
// Frame-granular arbiter: drains one source FIFO per frame onto a shared byte path, optional tag byte.
// Build option FRAME_ARB_STRICT_PRIO_EN selects lowest-index priority instead of round robin.
module message_frame_arbiter #(
  parameter int           NUM_SRC  = 4,
  parameter int           SRC_W    = 2,
  parameter int           TAG_EN   = 1,
  parameter logic [7:0]   TAG_BASE = 8'h80
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC-1:0]     src_frame_avail,
  input  logic [8*NUM_SRC-1:0]   src_data,
  input  logic [NUM_SRC-1:0]     src_last,
  output logic [NUM_SRC-1:0]     src_latch,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sof,
  output logic                   out_eof,
  output logic [SRC_W-1:0]       out_src,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, TAG, XFER} state_t;

  state_t           state, state_nxt;
  logic [SRC_W-1:0] gnt, gnt_nxt;
  logic [SRC_W-1:0] rr_ptr, rr_ptr_nxt;
  logic             first, first_nxt;
  logic             load_ok;
  logic             ld, ld_sof, ld_eof;
  logic [7:0]       ld_data;
  logic [7:0]       sel_data;
  logic             sel_last;

  // First requesting source at or after base, wrapping around NUM_SRC.
  function automatic logic [SRC_W-1:0] pick_src(input logic [NUM_SRC-1:0] req,
                                                input logic [SRC_W-1:0]   base);
    logic [SRC_W-1:0] sel;
    logic             found;
    logic [SRC_W:0]   idx;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = {1'b0, base} + (SRC_W+1)'(i);
      if (idx >= (SRC_W+1)'(NUM_SRC)) idx = idx - (SRC_W+1)'(NUM_SRC);
      if (!found && req[idx[SRC_W-1:0]]) begin
        sel   = idx[SRC_W-1:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [SRC_W-1:0] next_src(input logic [SRC_W-1:0] s);
    return (s == SRC_W'(NUM_SRC-1)) ? '0 : s + 1'b1;
  endfunction

  assign load_ok = !out_valid || out_ready;
  assign busy    = (state != IDLE);

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt == SRC_W'(i)) begin
        sel_data = src_data[8*i +: 8];
        sel_last = src_last[i];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    rr_ptr_nxt = rr_ptr;
    first_nxt  = first;
    ld         = 1'b0;
    ld_data    = sel_data;
    ld_sof     = 1'b0;
    ld_eof     = 1'b0;
    src_latch  = '0;
    case (state)
      IDLE: begin
        if (|src_frame_avail) begin
`ifdef FRAME_ARB_STRICT_PRIO_EN
          gnt_nxt = pick_src(src_frame_avail, '0);
`else
          gnt_nxt = pick_src(src_frame_avail, rr_ptr);
`endif
          first_nxt = 1'b1;
          state_nxt = (TAG_EN != 0) ? TAG : XFER;
        end
      end
      TAG: begin
        if (load_ok && !rst) begin
          ld        = 1'b1;
          ld_data   = TAG_BASE + 8'(gnt);
          ld_sof    = 1'b1;
          state_nxt = XFER;
        end
      end
      XFER: begin
        // Pop only together with a load so each head byte leaves exactly once.
        if (load_ok && !rst) begin
          ld        = 1'b1;
          ld_sof    = (TAG_EN == 0) && first;
          ld_eof    = sel_last;
          src_latch = NUM_SRC'(1) << gnt;
          first_nxt = 1'b0;
          if (sel_last) begin
            state_nxt = IDLE;
`ifndef FRAME_ARB_STRICT_PRIO_EN
            rr_ptr_nxt = next_src(gnt);
`endif
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      rr_ptr    <= '0;
      first     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_src   <= '0;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      rr_ptr <= rr_ptr_nxt;
      first  <= first_nxt;
      if (ld) begin
        out_valid <= 1'b1;
        out_data  <= ld_data;
        out_sof   <= ld_sof;
        out_eof   <= ld_eof;
        out_src   <= gnt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
